pixel_substitutor: RTL

Downstream consumer of the S-box generation stage.
- Captures the 256 S-box bytes as the generator writes them.
- Then encrypts a raster pixel stream with chained substitution: c[i] = S[p[i] ^ k[i]] ^ c[i-1], where c[-1] = IV.
- Keystream k comes from the chaotic generator alongside each pixel. Ciphertext goes to the image writer through a valid/ready interface.

---
 rtl/pixel_substitutor_pkg.sv | 19 +
 rtl/pixel_substitutor_if.sv | 37 +++
 rtl/pixel_substitutor_sbox_lut_ram.sv | 23 ++
 rtl/pixel_substitutor.sv | 108 ++++++++++
 4 files changed

// File: rtl/pixel_substitutor_pkg.sv
// Shared constants, state encoding and index helper for the pixel substitutor.
package pixel_substitutor_pkg;

  localparam int SBOX_DEPTH = 256;
  localparam int SBOX_AW    = 8;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // S-box lookup index: plaintext whitened by the keystream, wraps in 8 bits.
  function automatic logic [SBOX_AW-1:0] sbox_index(input logic [7:0] p,
                                                    input logic [7:0] k);
    return p ^ k;
  endfunction

endpackage

// File: rtl/pixel_substitutor_if.sv
// Bundle of the S-box load port, pixel input stream and ciphertext output stream.
interface pixel_substitutor_if #(
  parameter int CNT_W = 17
) ();

  logic             sbox_we;
  logic [7:0]       sbox_din;
  logic             sbox_done;
  logic             fill_done;
  logic             fill_err;
  logic             pix_valid;
  logic [7:0]       pix_data;
  logic [7:0]       key_data;
  logic             pix_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_ready;
  logic [CNT_W-1:0] pix_count;
  logic             frame_done;

  // Block side.
  modport slave (
    input  sbox_we, sbox_din, sbox_done,
    input  pix_valid, pix_data, key_data, out_ready,
    output fill_done, fill_err, pix_ready, out_valid, out_data,
    output pix_count, frame_done
  );

  // Producer / consumer side.
  modport master (
    output sbox_we, sbox_din, sbox_done,
    output pix_valid, pix_data, key_data, out_ready,
    input  fill_done, fill_err, pix_ready, out_valid, out_data,
    input  pix_count, frame_done
  );

endinterface

// File: rtl/pixel_substitutor_sbox_lut_ram.sv
// 256x8 S-box table: synchronous write, asynchronous read. Not reset; the
// contents are always reloaded before use.
module sbox_lut_ram
  import pixel_substitutor_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [SBOX_AW-1:0] waddr,
  input  logic [7:0]         wdata,
  input  logic [SBOX_AW-1:0] raddr,
  output logic [7:0]         rdata
);

  logic [7:0] mem_q [SBOX_DEPTH];

  // Capture one S-box entry per write strobe.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pixel_substitutor.sv
// Chained S-box substitution cipher: load the S-box, then encrypt a pixel
// stream as c[i] = S[p[i]^k[i]] ^ c[i-1], one-entry output register with
// valid/ready backpressure.
module pixel_substitutor
  import pixel_substitutor_pkg::*;
#(
  parameter int         NUM_PIXELS = 65536,
  parameter int         CNT_W      = 17,
  parameter logic [7:0] IV         = 8'h5A
) (
  input  logic                clk,
  input  logic                rst,
  pixel_substitutor_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PIXELS - 1);

  state_e             state_q, state_d;
  logic [SBOX_AW-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]         chain_q, chain_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fill_err_q, fill_err_d;

  logic               ram_we;
  logic [7:0]         sbox_val;
  logic [7:0]         cipher;
  logic               pix_ready;
  logic               in_hs, out_hs, last_wr;

  // Writes only land while filling, so the RAM is frozen once running.
  assign ram_we  = (state_q == ST_FILL) && bus.sbox_we;
  assign last_wr = ram_we && (wr_idx_q == 8'hFF);

  sbox_lut_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_idx_q),
    .wdata (bus.sbox_din),
    .raddr (sbox_index(bus.pix_data, bus.key_data)),
    .rdata (sbox_val)
  );

  assign cipher    = sbox_val ^ chain_q;
  assign pix_ready = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
  assign in_hs     = bus.pix_valid && pix_ready;
  assign out_hs    = out_valid_q && bus.out_ready;

  // Next state: fill sequencing, error flag, and the chained output stage.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    chain_d     = chain_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    fill_err_d  = fill_err_q;

    if (state_q == ST_FILL) begin
      if (ram_we) wr_idx_d = wr_idx_q + 8'd1;
      if (last_wr) state_d = ST_RUN;
      // A completing write in the same cycle as sbox_done is not an error.
      if (bus.sbox_done && !last_wr) fill_err_d = 1'b1;
    end

    // in_hs can only fire in RUN; DONE just drains the pending output.
    if (in_hs) begin
      out_data_d  = cipher;
      chain_d     = cipher;
      out_valid_d = 1'b1;
      cnt_d       = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_CNT) state_d = ST_DONE;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any pending output and restarts the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      wr_idx_q    <= '0;
      chain_q     <= IV;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      fill_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      chain_q     <= chain_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      fill_err_q  <= fill_err_d;
    end
  end

  assign bus.fill_done  = (state_q != ST_FILL);
  assign bus.frame_done = (state_q == ST_DONE);
  assign bus.fill_err   = fill_err_q;
  assign bus.pix_ready  = pix_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.pix_count  = cnt_q;

endmodule
